// File: rtl/song_matcher.sv
// song_matcher: key-sequence matcher. Holds a small song table and checks the
// player's synchronised key presses against a selected song, one note at a time.
module song_matcher #(
  parameter int NUM_NOTES     = 4,
  parameter int MAX_LEN       = 8,
  parameter int NUM_SONGS     = 8,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   tick,
  input  logic [NUM_NOTES-1:0]                                   keys_n,
  input  logic                                                   prog_we,
  input  logic [((NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1)-1:0]   prog_song,
  input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0]       prog_idx,
  input  logic [((NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1)-1:0]   prog_note,
  input  logic                                                   len_we,
  input  logic [$clog2(MAX_LEN+1)-1:0]                           prog_len,
  input  logic                                                   start,
  input  logic [((NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1)-1:0]   song_sel,
  output logic                                                   busy,
  output logic [$clog2(MAX_LEN+1)-1:0]                           progress,
  output logic                                                   done,
  output logic                                                   pass,
  output logic                                                   fail,
  output logic [1:0]                                             fail_code
);

  localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int NW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WAIT_PRESS   = 3'd1;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd2;
  localparam logic [2:0] ST_PASS         = 3'd3;
  localparam logic [2:0] ST_FAIL         = 3'd4;

  localparam logic [NUM_NOTES-1:0] KEY_NONE = {NUM_NOTES{1'b0}};
  localparam logic [NUM_NOTES-1:0] KEY_ONE  = {{(NUM_NOTES-1){1'b0}}, 1'b1};

  // True when more than one key bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [NUM_NOTES-1:0] v);
    return (v & (v - KEY_ONE)) != KEY_NONE;
  endfunction

  logic [NUM_NOTES-1:0] k_meta_r, k_r, k_prev_r;
  logic [2:0]           state_r;
  logic [SW-1:0]        song_r;
  logic [LW-1:0]        len_cur_r;
  logic [LW-1:0]        progress_r;
  logic [TW-1:0]        timer_r;
  logic                 busy_r, done_r, pass_r, fail_r;
  logic [1:0]           fail_code_r;
  logic [LW-1:0]        len_tab_r  [NUM_SONGS];
  logic [NW-1:0]        note_tab_r [NUM_SONGS][MAX_LEN];

  logic                 press_s, idx_ok_s, song_ok_s;
  logic [LW-1:0]        start_len_s, eff_len_s, prog_next_s;
  logic [NW-1:0]        exp_note_s;
  logic [NUM_NOTES-1:0] exp_key_s;

  assign busy      = busy_r;
  assign progress  = progress_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign fail_code = fail_code_r;

  // Decode press events, clamp the stored length and look up the expected note.
  always_comb begin
    press_s     = (k_prev_r == KEY_NONE) && (k_r != KEY_NONE);
    idx_ok_s    = ({1'b0, prog_idx} < (IW+1)'(MAX_LEN));
    song_ok_s   = ({1'b0, prog_song} < (SW+1)'(NUM_SONGS));
    start_len_s = len_tab_r[song_sel];
    if (start_len_s > LW'(MAX_LEN)) begin
      eff_len_s = LW'(MAX_LEN);
    end else begin
      eff_len_s = start_len_s;
    end
    prog_next_s = progress_r + LW'(1);
    exp_note_s  = note_tab_r[song_r][progress_r[IW-1:0]];
    exp_key_s   = KEY_ONE << exp_note_s;
  end

  // Invert the active-low keys and bring them into the clock domain; keep last cycle's value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_meta_r <= KEY_NONE;
      k_r      <= KEY_NONE;
      k_prev_r <= KEY_NONE;
    end else begin
      k_meta_r <= ~keys_n;
      k_r      <= k_meta_r;
      k_prev_r <= k_r;
    end
  end

  // Note table write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_r && idx_ok_s && song_ok_s) begin
      note_tab_r[prog_song][prog_idx] <= prog_note;
    end
  end

  // Song length table; lengths reset to zero so unprogrammed songs fail cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SONGS; i++) begin
        len_tab_r[i] <= {LW{1'b0}};
      end
    end else if (len_we && !busy_r && song_ok_s) begin
      len_tab_r[prog_song] <= prog_len;
    end
  end

  // Match FSM with registered status outputs; done pulses on entry to PASS/FAIL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      song_r      <= {SW{1'b0}};
      len_cur_r   <= {LW{1'b0}};
      progress_r  <= {LW{1'b0}};
      timer_r     <= {TW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_code_r <= 2'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_WAIT_PRESS: begin
          if (press_s) begin
            if (multi_hot(k_r)) begin
              state_r     <= ST_FAIL;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= 2'd2;
            end else if (k_r == exp_key_s) begin
              state_r <= ST_WAIT_RELEASE;
              timer_r <= {TW{1'b0}};
            end else begin
              state_r     <= ST_FAIL;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= 2'd1;
            end
          end else if (tick) begin
            if (timer_r == TW'(TIMEOUT_TICKS - 1)) begin
              state_r     <= ST_FAIL;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= 2'd3;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
        end
        ST_WAIT_RELEASE: begin
          // Timer frozen here; extra keys are ignored until everything is released.
          if (k_r == KEY_NONE) begin
            progress_r <= prog_next_s;
            if (prog_next_s == len_cur_r) begin
              state_r <= ST_PASS;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= 1'b1;
            end else begin
              state_r <= ST_WAIT_PRESS;
            end
          end
        end
        default: begin
          // IDLE, PASS and FAIL are all idle from the outside: accept a new start.
          if (start) begin
            song_r     <= song_sel;
            len_cur_r  <= eff_len_s;
            progress_r <= {LW{1'b0}};
            pass_r     <= 1'b0;
            timer_r    <= {TW{1'b0}};
            if (eff_len_s == {LW{1'b0}}) begin
              state_r     <= ST_FAIL;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= 2'd3;
            end else begin
              state_r     <= ST_WAIT_PRESS;
              busy_r      <= 1'b1;
              fail_r      <= 1'b0;
              fail_code_r <= 2'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
